// File: rtl/jtag_tap_pkg.sv
// Shared constants for the parametrised JTAG TAP: state encodings, opcode bases,
// IR capture pattern and the DR path selector type.
package jtag_tap_pkg;

  localparam logic [3:0] ST_EX2_DR = 4'h0;
  localparam logic [3:0] ST_EX1_DR = 4'h1;
  localparam logic [3:0] ST_SH_DR  = 4'h2;
  localparam logic [3:0] ST_PAU_DR = 4'h3;
  localparam logic [3:0] ST_SEL_IR = 4'h4;
  localparam logic [3:0] ST_UPD_DR = 4'h5;
  localparam logic [3:0] ST_CAP_DR = 4'h6;
  localparam logic [3:0] ST_SEL_DR = 4'h7;
  localparam logic [3:0] ST_EX2_IR = 4'h8;
  localparam logic [3:0] ST_EX1_IR = 4'h9;
  localparam logic [3:0] ST_SH_IR  = 4'hA;
  localparam logic [3:0] ST_PAU_IR = 4'hB;
  localparam logic [3:0] ST_RTI    = 4'hC;
  localparam logic [3:0] ST_UPD_IR = 4'hD;
  localparam logic [3:0] ST_CAP_IR = 4'hE;
  localparam logic [3:0] ST_TLR    = 4'hF;

  typedef enum logic [3:0] {
    S_EX2_DR = ST_EX2_DR,
    S_EX1_DR = ST_EX1_DR,
    S_SH_DR  = ST_SH_DR,
    S_PAU_DR = ST_PAU_DR,
    S_SEL_IR = ST_SEL_IR,
    S_UPD_DR = ST_UPD_DR,
    S_CAP_DR = ST_CAP_DR,
    S_SEL_DR = ST_SEL_DR,
    S_EX2_IR = ST_EX2_IR,
    S_EX1_IR = ST_EX1_IR,
    S_SH_IR  = ST_SH_IR,
    S_PAU_IR = ST_PAU_IR,
    S_RTI    = ST_RTI,
    S_UPD_IR = ST_UPD_IR,
    S_CAP_IR = ST_CAP_IR,
    S_TLR    = ST_TLR
  } tap_state_t;

  localparam int unsigned OP_IDCODE    = 1;
  localparam int unsigned OP_USER_BASE = 2;
  localparam logic [1:0]  IR_CAPTURE   = 2'b01;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER,
    DR_USERCODE
  } dr_sel_t;

  // BYPASS is all ones for whatever IR width the core is built with.
  function automatic int unsigned op_bypass(int unsigned ir_width);
    return (1 << ir_width) - 1;
  endfunction

  function automatic int unsigned op_usercode(int unsigned ir_width);
    return (1 << ir_width) - 2;
  endfunction

endpackage

// File: rtl/jtag_tap_if.sv
// Serial JTAG pins between a test controller (master) and the TAP (slave).
interface jtag_tap_if;
  logic TMS;
  logic TDI;
  logic TDO;
  logic TDO_EN;

  modport master (output TMS, output TDI, input TDO, input TDO_EN);
  modport slave  (input TMS, input TDI, output TDO, output TDO_EN);
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller; exposes the current and next state so the
// datapath can act on the edge that enters TEST_LOGIC_RESET.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST_N,
  input  logic       TMS,
  output tap_state_t state,
  output tap_state_t state_next,
  output logic       tlr
);

  tap_state_t state_reg;
  tap_state_t next_c;

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_reg <= S_TLR;
    end else begin
      state_reg <= next_c;
    end
  end

  always_comb begin
    next_c = state_reg;
    case (state_reg)
      S_TLR:    next_c = TMS ? S_TLR    : S_RTI;
      S_RTI:    next_c = TMS ? S_SEL_DR : S_RTI;
      S_SEL_DR: next_c = TMS ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: next_c = TMS ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  next_c = TMS ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: next_c = TMS ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: next_c = TMS ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: next_c = TMS ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: next_c = TMS ? S_SEL_DR : S_RTI;
      S_SEL_IR: next_c = TMS ? S_TLR    : S_CAP_IR;
      S_CAP_IR: next_c = TMS ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  next_c = TMS ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: next_c = TMS ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: next_c = TMS ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: next_c = TMS ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: next_c = TMS ? S_SEL_DR : S_RTI;
      default:  next_c = S_TLR;
    endcase
  end

  assign state      = state_reg;
  assign state_next = next_c;
  assign tlr        = (state_reg == S_TLR);

endmodule

// File: rtl/jtag_tap_core.sv
// Parametrised JTAG TAP: IR, BYPASS/IDCODE/USERk data registers, update buses and
// a falling-edge TDO stage. Define TAP_USERCODE_EN to add the USERCODE register.
module jtag_tap_core
  import jtag_tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE_VAL    = 32'h1000_0001,
  parameter int unsigned NUM_USER_DR   = 4,
  parameter int unsigned USER_DR_WIDTH = 16
`ifdef TAP_USERCODE_EN
  ,
  parameter logic [31:0] USERCODE_VAL  = 32'h0000_0000
`endif
) (
  input  logic                                   TCK,
  input  logic                                   TRST_N,
  jtag_tap_if.slave                              jtag,
  output logic [3:0]                             state,
  output logic [IR_WIDTH-1:0]                    ir_latched,
  input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   dr_capture,
  output logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   dr_update,
  output logic [NUM_USER_DR-1:0]                 dr_update_stb,
  output logic                                   tlr
);

  localparam int unsigned W = USER_DR_WIDTH;
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OP_IDCODE);
`ifdef TAP_USERCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_USERCODE = IR_WIDTH'(op_usercode(IR_WIDTH));
`endif

  tap_state_t cur_state;
  tap_state_t nxt_state;

  logic [IR_WIDTH-1:0]    ir_sr_reg;
  logic [IR_WIDTH-1:0]    ir_latched_reg;
  logic                   bypass_reg;
  logic [31:0]            dr32_reg;
  logic [W-1:0]           user_sr_reg;
  logic                   tdo_reg;
  logic                   tdo_en_reg;

  logic [NUM_USER_DR-1:0] user_hit;
  dr_sel_t                dr_sel;
  logic [W-1:0]           user_cap;
  logic                   dr_bit0;
  logic                   tdo_next;
  logic                   shifting;

  jtag_tap_fsm u_fsm (
    .TCK        (TCK),
    .TRST_N     (TRST_N),
    .TMS        (jtag.TMS),
    .state      (cur_state),
    .state_next (nxt_state),
    .tlr        (tlr)
  );

  assign state      = cur_state;
  assign ir_latched = ir_latched_reg;

  // One-hot user channel decode; codes beyond the populated channels fall to BYPASS.
  for (genvar gi = 0; gi < NUM_USER_DR; gi++) begin : g_hit
    assign user_hit[gi] = (ir_latched_reg == IR_WIDTH'(OP_USER_BASE + gi));
  end

  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_latched_reg == IR_IDCODE) begin
      dr_sel = DR_IDCODE;
    end else if (|user_hit) begin
      dr_sel = DR_USER;
    end
`ifdef TAP_USERCODE_EN
    else if (ir_latched_reg == IR_USERCODE) begin
      dr_sel = DR_USERCODE;
    end
`endif
  end

  always_comb begin
    user_cap = '0;
    for (int k = 0; k < int'(NUM_USER_DR); k++) begin
      if (user_hit[k]) begin
        user_cap = dr_capture[k*W +: W];
      end
    end
  end

  // Instruction path: entering TLR forces IDCODE, otherwise only UPD_IR changes it.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_sr_reg      <= '0;
      ir_latched_reg <= IR_IDCODE;
    end else begin
      if (cur_state == S_CAP_IR) begin
        ir_sr_reg <= IR_WIDTH'(IR_CAPTURE);
      end else if (cur_state == S_SH_IR) begin
        ir_sr_reg <= IR_WIDTH'({jtag.TDI, ir_sr_reg} >> 1);
      end

      if (nxt_state == S_TLR) begin
        ir_latched_reg <= IR_IDCODE;
      end else if (cur_state == S_UPD_IR) begin
        ir_latched_reg <= ir_sr_reg;
      end
    end
  end

  // IDCODE and USERCODE never coexist in one scan, so they share the 32-bit register.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      bypass_reg  <= 1'b0;
      dr32_reg    <= '0;
      user_sr_reg <= '0;
    end else if (cur_state == S_CAP_DR) begin
      case (dr_sel)
        DR_IDCODE: dr32_reg    <= IDCODE_VAL;
        DR_USER:   user_sr_reg <= user_cap;
`ifdef TAP_USERCODE_EN
        DR_USERCODE: dr32_reg  <= USERCODE_VAL;
`endif
        default:   bypass_reg  <= 1'b0;
      endcase
    end else if (cur_state == S_SH_DR) begin
      case (dr_sel)
        DR_IDCODE, DR_USERCODE: dr32_reg <= {jtag.TDI, dr32_reg[31:1]};
        DR_USER:   user_sr_reg <= W'({jtag.TDI, user_sr_reg} >> 1);
        default:   bypass_reg  <= jtag.TDI;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_USER_DR; gi++) begin : g_user
    logic [W-1:0] upd_reg;
    logic         stb_reg;

    always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N) begin
        upd_reg <= '0;
        stb_reg <= 1'b0;
      end else begin
        stb_reg <= 1'b0;
        if (cur_state == S_UPD_DR && user_hit[gi]) begin
          upd_reg <= user_sr_reg;
          stb_reg <= 1'b1;
        end
      end
    end

    assign dr_update[gi*W +: W] = upd_reg;
    assign dr_update_stb[gi]    = stb_reg;
  end

  always_comb begin
    dr_bit0 = bypass_reg;
    case (dr_sel)
      DR_IDCODE, DR_USERCODE: dr_bit0 = dr32_reg[0];
      DR_USER:                dr_bit0 = user_sr_reg[0];
      default:                ;
    endcase
  end

  always_comb begin
    shifting = (cur_state == S_SH_IR) || (cur_state == S_SH_DR);
    tdo_next = 1'b0;
    if (cur_state == S_SH_IR) begin
      tdo_next = ir_sr_reg[0];
    end else if (cur_state == S_SH_DR) begin
      tdo_next = dr_bit0;
    end
  end

  // Launching on the falling edge gives the far end half a TCK of setup margin.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      tdo_reg    <= 1'b0;
      tdo_en_reg <= 1'b0;
    end else begin
      tdo_reg    <= tdo_next;
      tdo_en_reg <= shifting;
    end
  end

  assign jtag.TDO    = tdo_reg;
  assign jtag.TDO_EN = tdo_en_reg;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Self-checking bench for jtag_tap_core: directed test-plan scans plus randomized
// TMS/TDI traffic, all compared each cycle against a queue-based reference model.
module tb_jtag_tap_core;

  localparam int IRW = 4;
  localparam int NUM = 4;
  localparam int W   = 16;
  localparam logic [31:0] IDC = 32'h1000_0001;

  // Successor state by encoding, for TMS=0 and TMS=1.
  localparam int NX0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  localparam int NX1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

  logic               TCK = 1'b0;
  logic               TRST_N = 1'b0;
  logic [NUM*W-1:0]   dr_capture;
  logic [3:0]         state;
  logic [IRW-1:0]     ir_latched;
  logic [NUM*W-1:0]   dr_update;
  logic [NUM-1:0]     dr_update_stb;
  logic               tlr;

  jtag_tap_if jtag ();

  jtag_tap_core #(
    .IR_WIDTH      (IRW),
    .IDCODE_VAL    (IDC),
    .NUM_USER_DR   (NUM),
    .USER_DR_WIDTH (W)
  ) dut (
    .TCK           (TCK),
    .TRST_N        (TRST_N),
    .jtag          (jtag),
    .state         (state),
    .ir_latched    (ir_latched),
    .dr_capture    (dr_capture),
    .dr_update     (dr_update),
    .dr_update_stb (dr_update_stb),
    .tlr           (tlr)
  );

  always #5 TCK = ~TCK;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  int             m_state;
  int             m_ir;
  bit             ir_q[$];
  bit             dr_q[$];
  logic [NUM*W-1:0] m_upd;
  logic [NUM-1:0] m_stb;
  bit             e_tdo;
  bit             e_en;

  function automatic logic [31:0] q2int(input bit q[$]);
    logic [31:0] v;
    v = '0;
    foreach (q[i]) if (i < 32) v[i] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    m_state = 15;
    m_ir    = 1;
    ir_q.delete();
    repeat (IRW) ir_q.push_back(1'b0);
    dr_q.delete();
    dr_q.push_back(1'b0);
    m_upd = '0;
    m_stb = '0;
  endtask

  task automatic model_step(input bit tms, input bit tdi);
    logic [NUM-1:0] stb_n;
    int k;
    stb_n = '0;
    k = m_ir - 2;
    case (m_state)
      14: begin
        ir_q.delete();
        ir_q.push_back(1'b1);
        repeat (IRW - 1) ir_q.push_back(1'b0);
      end
      10: begin
        void'(ir_q.pop_front());
        ir_q.push_back(tdi);
      end
      13: m_ir = int'(q2int(ir_q));
      6: begin
        dr_q.delete();
        if (m_ir == 1) begin
          for (int i = 0; i < 32; i++) dr_q.push_back(IDC[i]);
        end else if (k >= 0 && k < NUM) begin
          for (int i = 0; i < W; i++) dr_q.push_back(dr_capture[k*W + i]);
        end
`ifdef TAP_USERCODE_EN
        else if (m_ir == (1 << IRW) - 2) begin
          for (int i = 0; i < 32; i++) dr_q.push_back(1'b0);
        end
`endif
        else begin
          dr_q.push_back(1'b0);
        end
      end
      2: begin
        void'(dr_q.pop_front());
        dr_q.push_back(tdi);
      end
      5: begin
        if (k >= 0 && k < NUM) begin
          m_upd[k*W +: W] = W'(q2int(dr_q));
          stb_n[k] = 1'b1;
        end
      end
      default: ;
    endcase
    m_stb   = stb_n;
    m_state = tms ? NX1[m_state] : NX0[m_state];
    if (m_state == 15) m_ir = 1;
  endtask

  always @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) model_reset();
    else model_step(jtag.TMS, jtag.TDI);
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    cmp(name, act, exp);
  endtask

  // Outputs are stable between the falling edge and the next rising edge.
  always @(negedge TCK) begin
    #2;
    if (check_en) begin
      e_en  = (m_state == 10) || (m_state == 2);
      e_tdo = (m_state == 10) ? ir_q[0] : ((m_state == 2) ? dr_q[0] : 1'b0);
      vectors++;
      cmp("state", 64'(state), 64'(m_state));
      cmp("tlr", 64'(tlr), 64'(m_state == 15));
      cmp("ir_latched", 64'(ir_latched), 64'(m_ir));
      cmp("TDO_EN", 64'(jtag.TDO_EN), 64'(e_en));
      cmp("TDO", 64'(jtag.TDO), 64'(e_tdo));
      cmp("dr_update", 64'(dr_update), 64'(m_upd));
      cmp("dr_update_stb", 64'(dr_update_stb), 64'(m_stb));
    end
  end

  task automatic tick(input bit tms, input bit tdi);
    jtag.TMS = tms;
    jtag.TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #3;
  endtask

  task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = jtag.TDO;
      tick(i == n - 1, din[i]);
    end
  endtask

  task automatic to_rti();
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [IRW-1:0] op, output logic [31:0] dout);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    shift_bits(IRW, 32'(op), dout);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic enter_sh_dr();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    enter_sh_dr();
    shift_bits(n, din, dout);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] o;
    logic [31:0] o1;
    logic [31:0] o2;
    int mode;

    jtag.TMS = 1'b1;
    jtag.TDI = 1'b0;
    dr_capture = {$urandom, $urandom};
    TRST_N = 1'b0;
    @(negedge TCK);
    #3;
    check_en = 1'b1;
    @(negedge TCK);
    #3;
    check_lit("rst_state", 64'(state), 64'hF);
    check_lit("rst_tlr", 64'(tlr), 64'h1);
    check_lit("rst_tdo_en", 64'(jtag.TDO_EN), 64'h0);
    check_lit("rst_tdo", 64'(jtag.TDO), 64'h0);
    check_lit("rst_ir", 64'(ir_latched), 64'h1);
    check_lit("rst_upd", 64'(dr_update), 64'h0);
    TRST_N = 1'b1;
    tick(1'b0, 1'b0);

    scan_dr(32, $urandom, o);
    check_lit("idcode_read", 64'(o), 64'h1000_0001);
    check_lit("idcode_ir", 64'(ir_latched), 64'h1);

    load_ir(4'hF, o);
    check_lit("ir_capture_tdo", 64'(o[3:0]), 64'h1);
    check_lit("ir_after_upd", 64'(ir_latched), 64'hF);

    scan_dr(4, 32'b1101, o);
    check_lit("bypass_tdo", 64'(o[3:0]), 64'hA);
    load_ir(4'h0, o);
    scan_dr(4, 32'b1101, o);
    check_lit("bypass_op0_tdo", 64'(o[3:0]), 64'hA);

    dr_capture[2*W +: W] = 16'hA5C3;
    load_ir(4'h4, o);
    enter_sh_dr();
    shift_bits(16, 32'h1234, o);
    check_lit("user2_read", 64'(o[15:0]), 64'hA5C3);
    tick(1'b1, 1'b0);
    check_lit("user2_stb_pre", 64'(dr_update_stb), 64'h0);
    tick(1'b0, 1'b0);
    check_lit("user2_stb", 64'(dr_update_stb), 64'h4);
    check_lit("user2_update", 64'(dr_update), 64'h0000_1234_0000_0000);
    tick(1'b0, 1'b0);
    check_lit("user2_stb_end", 64'(dr_update_stb), 64'h0);

    enter_sh_dr();
    repeat (4) tick(1'b1, 1'b0);
    check_lit("tms_rst_4th", 64'(state), 64'h4);
    tick(1'b1, 1'b0);
    check_lit("tms_rst_state", 64'(state), 64'hF);
    check_lit("tms_rst_ir", 64'(ir_latched), 64'h1);
    tick(1'b0, 1'b0);

    dr_capture[1*W +: W] = 16'h3C5A;
    load_ir(4'h3, o);
    enter_sh_dr();
    shift_bits(6, 32'hBEEF, o1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    shift_bits(10, 32'hBEEF >> 6, o2);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check_lit("pause_read", 64'({o2[9:0], o1[5:0]}), 64'h3C5A);
    check_lit("pause_update", 64'(dr_update[1*W +: W]), 64'hBEEF);

    load_ir(4'h2, o);
    enter_sh_dr();
    repeat (7) tick(1'b0, 1'($urandom_range(0, 1)));
    TRST_N = 1'b0;
    #20;
    check_lit("abort_state", 64'(state), 64'hF);
    check_lit("abort_tdo_en", 64'(jtag.TDO_EN), 64'h0);
    check_lit("abort_upd", 64'(dr_update), 64'h0);
    check_lit("abort_stb", 64'(dr_update_stb), 64'h0);
    TRST_N = 1'b1;
    tick(1'b0, 1'b0);

    for (int it = 0; it < 200; it++) begin
      mode = int'($urandom_range(0, 9));
      if (mode < 3) begin
        for (int j = 0; j < 20; j++) begin
          tick($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)));
        end
      end else if (mode == 3) begin
        TRST_N = 1'b0;
        #10;
        TRST_N = 1'b1;
      end else begin
        to_rti();
        load_ir(IRW'($urandom_range(0, 15)), o);
        if ($urandom_range(0, 1) == 1) dr_capture = {$urandom, $urandom};
        scan_dr(int'($urandom_range(1, 32)), $urandom, o);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jtag_tap_core.md
# jtag_tap_core

Parametrised IEEE 1149.1 TAP core: 16-state controller, IR of configurable width, BYPASS, IDCODE and a configurable number of user data-register channels. It replaces the fixed 4-bit-IR TAP front end and fans out parallel capture/update buses to the board-test, BIST and core-logic blocks. Everything runs on TCK. TDO is launched on the falling edge, which the previous generation did not do.

## Interface
- `IR_WIDTH`, default 4: instruction register width, ≥ 2.
- `IDCODE_VAL`, default 32'h1000_0001: value captured in IDCODE. Bit 0 must be 1.
- `NUM_USER_DR`, default 4: number of user DR channels, 1..(2^IR_WIDTH − 4).
- `USER_DR_WIDTH`, default 16: width of every user DR, ≥ 1.
- `TCK` input, 1: test clock. This is the only clock.
- `TRST_N` input, 1: asynchronous, active-low reset.
- `TMS` input, 1: mode select, sampled on rising TCK.
- `TDI` input, 1: serial in, sampled on rising TCK.
- `TDO` output, 1: serial out, updated on falling TCK.
- `TDO_EN` output, 1: high while serial data is valid.
- `state` output, 4: current TAP state encoding.
- `ir_latched` output, IR_WIDTH: active instruction.
- `dr_capture` input, NUM_USER_DR*USER_DR_WIDTH: parallel capture data. Channel k is at [k*W +: W].
- `dr_update` output, NUM_USER_DR*USER_DR_WIDTH: parallel update registers.
- `dr_update_stb` output, NUM_USER_DR: one-TCK pulse when channel k is updated.
- `tlr` output, 1: high in TEST_LOGIC_RESET.

## Operation
- State encodings:
  - TLR F, RTI C, SEL_DR 7, CAP_DR 6, SH_DR 2, EX1_DR 1, PAU_DR 3, EX2_DR 0, UPD_DR 5.
  - SEL_IR 4, CAP_IR E, SH_IR A, EX1_IR 9, PAU_IR B, EX2_IR 8, UPD_IR D.
- Transitions follow IEEE 1149.1 on TMS at rising TCK. Five consecutive TMS=1 reach TLR from any state.
- Opcodes:
  - BYPASS = all ones.
  - IDCODE = 1.
  - USERk = 2+k.
  - USERCODE = 2^IR_WIDTH − 2 (see Configuration).
  - 0 and every unassigned code decode as BYPASS.
- IR path:
  - CAP_IR loads the shift register with {0…0, 2'b01}.
  - SH_IR shifts right, TDI into the MSB.
  - Rising edge in UPD_IR copies the shift register to `ir_latched`.
- DR path by decoded instruction:
  - IDCODE: 32-bit register, captures IDCODE_VAL.
  - BYPASS: 1-bit register, captures 0.
  - USERk: W-bit register, captures channel k of `dr_capture`.
  - All DRs shift right, LSB out first.
- Rising edge in UPD_DR with USERk selected:
  - copies the shift register into channel k of `dr_update`;
  - `dr_update_stb[k]` = 1 for the following cycle.
  - Other channels are untouched.
- TLR state (entered via TMS or TRST_N): `ir_latched` = IDCODE. `dr_update` is held, not cleared, when TLR is entered via TMS.
- Reset values on TRST_N low:
  - state = F, `ir_latched` = IDCODE, all shift registers 0;
  - `dr_update` = 0, `dr_update_stb` = 0;
  - TDO = 0, TDO_EN = 0, `tlr` = 1.
- Reset mid-shift aborts the shift. No update strobe fires.

## Timing
- `state` and `tlr` change on rising TCK.
- TDO/TDO_EN register on falling TCK:
  - TDO = shift-register bit 0 of the selected path;
  - TDO_EN = 1 iff state is SH_IR or SH_DR.
- The first valid TDO bit appears on the falling edge after the rising edge that enters SH_x.
- While TDO_EN = 0, TDO holds 0.
- Update-to-output latency: the rising edge that leaves UPD_x. The `dr_update_stb` pulse width is exactly one TCK.
- `ir_latched` changes only in UPD_IR. The DR selection used in CAP_DR/SH_DR/UPD_DR is the value latched at that moment.
- PAU_x and EX2_x hold the shift contents unchanged. Resuming SH_x continues the same scan.

## Configuration
- `TAP_USERCODE_EN` defined:
  - adds parameter `USERCODE_VAL` (default 32'h0000_0000);
  - opcode 2^IR_WIDTH − 2 selects a 32-bit register that captures it.
- `TAP_USERCODE_EN` undefined: that opcode decodes as BYPASS and no register is built.

## Structure
- Package `jtag_tap_pkg` holds the 16 state localparams, the BYPASS/IDCODE/USER-base opcode constants and the IR capture pattern.
- One sub-module, `jtag_tap_fsm`, contains the state register, next-state logic and the `tlr` output.
- `jtag_tap_core` contains the IR, DR shift registers, decode, update registers and the falling-edge TDO stage.

## Test plan
- Reset then IDCODE read: TRST_N pulse, then TMS 0,1,0,0 and 32 shifts → TDO LSB-first yields IDCODE_VAL; `ir_latched` = 1.
- TMS reset from SH_DR: five TMS=1 → `state` = F on the 5th edge; `ir_latched` = 1.
- IR capture: enter SH_IR, shift 4 bits of 4'hF → TDO shows 1,0,0,0. After UPD_IR, `ir_latched` = 4'hF.
- Bypass: BYPASS loaded, shift 1,0,1,1 → TDO 0,1,0,1 (one-bit delay). Opcode 0 behaves identically.
- User write/read: load USER2, `dr_capture` ch2 = 16'hA5C3, shift in 16'h1234 → TDO yields A5C3. After UPD_DR, ch2 `dr_update` = 1234 and `dr_update_stb` = 3'b100 pulse for one cycle. Other channels are unchanged.
- Abort: TRST_N asserted at shift bit 7 of USER0 → no strobe; `dr_update` = 0; state = F; TDO_EN = 0.
